// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes, ownership decode, square packing
// and the move controller state encoding.
package chess_pkg;

  localparam int TIMEOUT = 255;
  localparam int TMO_W   = 8;

  localparam logic [3:0] PC_EMPTY  = 4'd0;
  localparam logic [3:0] W_PAWN    = 4'd1;
  localparam logic [3:0] W_KNIGHT  = 4'd2;
  localparam logic [3:0] W_BISHOP  = 4'd3;
  localparam logic [3:0] W_ROOK    = 4'd4;
  localparam logic [3:0] W_QUEEN   = 4'd5;
  localparam logic [3:0] W_KING    = 4'd6;
  localparam logic [3:0] B_PAWN    = 4'd7;
  localparam logic [3:0] B_KNIGHT  = 4'd8;
  localparam logic [3:0] B_BISHOP  = 4'd9;
  localparam logic [3:0] B_ROOK    = 4'd10;
  localparam logic [3:0] B_QUEEN   = 4'd11;
  localparam logic [3:0] B_KING    = 4'd12;

  typedef struct packed {
    logic empty;
    logic player;
  } owner_t;

  typedef enum logic [3:0] {
    IDLE_SRC  = 4'd0,
    READ_SRC  = 4'd1,
    CHECK_SRC = 4'd2,
    WAIT_DST  = 4'd3,
    READ_DST  = 4'd4,
    CHECK_DST = 4'd5,
    VALIDATE  = 4'd6,
    WRITE_DST = 4'd7,
    WRITE_SRC = 4'd8,
    DONE      = 4'd9,
    GAME_OVER = 4'd10
  } ctrl_state_t;

  // Codes 13..15 never appear on a legal board; they are treated as empty.
  function automatic owner_t piece_owner(input logic [3:0] code);
    owner_t o;
    o.empty  = (code == PC_EMPTY) || (code > B_KING);
    o.player = (code >= B_PAWN) && !o.empty;
    return o;
  endfunction

  function automatic logic [5:0] square_addr(input logic [2:0] x, input logic [2:0] y);
    return {x, y};
  endfunction

endpackage

// File: rtl/move_timeout_counter.sv
// Validation watchdog: up-counter with clear/enable. terminal fires in the
// cycle whose increment lands the count on TIMEOUT.
module move_timeout_counter
  import chess_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [TMO_W-1:0] count,
  output logic             terminal
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = enable && (count == TMO_W'(TIMEOUT - 1));

endmodule

// File: rtl/move_controller.sv
// Chess turn sequencer: source/destination selection, validator hand-off with
// shared board RAM port, move commit, side-to-move and game-over tracking.
module move_controller
  import chess_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       select,
  input  logic [2:0] cursor_x,
  input  logic [2:0] cursor_y,
  output logic [5:0] mem_addr,
  input  logic [3:0] mem_rdata,
  output logic [3:0] mem_wdata,
  output logic       mem_we,
  output logic       start_validation,
  output logic [3:0] piece_to_move,
  output logic [2:0] origin_x,
  output logic [2:0] origin_y,
  output logic [2:0] destination_x,
  output logic [2:0] destination_y,
  output logic [3:0] piece_read,
  input  logic [5:0] address_validator,
  input  logic       move_valid,
  input  logic       validate_complete,
  output logic       current_player,
  output logic       busy,
  output logic       move_done,
  output logic       move_rejected,
  output logic       game_over,
  output logic       winner,
  output logic [3:0] dbg_state
);

  ctrl_state_t      state;
  ctrl_state_t      state_next;
  logic [3:0]       captured;
  logic [TMO_W-1:0] tmo_count;
  logic             tmo_terminal;
  logic             tmo_clear;
  logic             tmo_enable;
  owner_t           rd_owner;
  logic             rd_own_piece;
  logic             sel_on_origin;
  logic             king_captured;
  logic             first_val_cycle;
  logic [5:0]       ctrl_addr;

  assign tmo_enable = (state == VALIDATE);
  assign tmo_clear  = (state != VALIDATE);

  move_timeout_counter u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear    (tmo_clear),
    .enable   (tmo_enable),
    .count    (tmo_count),
    .terminal (tmo_terminal)
  );

  assign rd_owner        = piece_owner(mem_rdata);
  assign rd_own_piece    = !rd_owner.empty && (rd_owner.player == current_player);
  assign sel_on_origin   = (cursor_x == origin_x) && (cursor_y == origin_y);
  assign king_captured   = (captured == W_KING) || (captured == B_KING);
  // A count of zero in VALIDATE means this is the entry cycle.
  assign first_val_cycle = (tmo_count == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE_SRC;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    move_rejected = 1'b0;
    case (state)
      IDLE_SRC: begin
        if (select) state_next = READ_SRC;
      end
      READ_SRC:  state_next = CHECK_SRC;
      CHECK_SRC: begin
        if (rd_own_piece) begin
          state_next = WAIT_DST;
        end else begin
          move_rejected = 1'b1;
          state_next    = IDLE_SRC;
        end
      end
      WAIT_DST: begin
        if (select) state_next = sel_on_origin ? IDLE_SRC : READ_DST;
      end
      READ_DST:  state_next = CHECK_DST;
      CHECK_DST: state_next = rd_own_piece ? WAIT_DST : VALIDATE;
      VALIDATE: begin
        // The validator needs one cycle to see its request before answering.
        if (validate_complete && !first_val_cycle) begin
          if (move_valid) begin
            state_next = WRITE_DST;
          end else begin
            move_rejected = 1'b1;
            state_next    = IDLE_SRC;
          end
        end else if (tmo_terminal) begin
          move_rejected = 1'b1;
          state_next    = IDLE_SRC;
        end
      end
      WRITE_DST: state_next = WRITE_SRC;
      WRITE_SRC: state_next = DONE;
      DONE:      state_next = king_captured ? GAME_OVER : IDLE_SRC;
      GAME_OVER: state_next = GAME_OVER;
      default:   state_next = IDLE_SRC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      origin_x       <= '0;
      origin_y       <= '0;
      destination_x  <= '0;
      destination_y  <= '0;
      piece_to_move  <= '0;
      captured       <= '0;
      current_player <= 1'b0;
      game_over      <= 1'b0;
      winner         <= 1'b0;
    end else begin
      case (state)
        IDLE_SRC: begin
          if (select) begin
            origin_x <= cursor_x;
            origin_y <= cursor_y;
          end
        end
        CHECK_SRC: begin
          if (rd_own_piece) piece_to_move <= mem_rdata;
        end
        WAIT_DST: begin
          if (select && !sel_on_origin) begin
            destination_x <= cursor_x;
            destination_y <= cursor_y;
          end
        end
        CHECK_DST: begin
          // Clicking another own piece switches the selection to it.
          if (rd_own_piece) begin
            origin_x      <= destination_x;
            origin_y      <= destination_y;
            piece_to_move <= mem_rdata;
          end else begin
            captured <= mem_rdata;
          end
        end
        DONE: begin
          if (king_captured) begin
            game_over <= 1'b1;
            winner    <= current_player;
          end else begin
            current_player <= ~current_player;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ctrl_addr = ((state == READ_DST) || (state == WRITE_DST))
                   ? square_addr(destination_x, destination_y)
                   : square_addr(origin_x, origin_y);

  assign mem_addr         = (state == VALIDATE) ? address_validator : ctrl_addr;
  assign mem_we           = (state == WRITE_DST) || (state == WRITE_SRC);
  assign mem_wdata        = (state == WRITE_DST) ? piece_to_move : PC_EMPTY;
  assign start_validation = (state == VALIDATE);
  assign piece_read       = mem_rdata;
  assign move_done        = (state == DONE);
  assign busy             = !((state == IDLE_SRC) || (state == WAIT_DST) || (state == GAME_OVER));
  assign dbg_state        = state;

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller with a behavioural board RAM and a
// scripted validator; RAM writes are scored against an expected queue.
module tb_move_controller;
  import chess_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       select = 1'b0;
  logic [2:0] cursor_x = '0;
  logic [2:0] cursor_y = '0;
  logic [5:0] mem_addr;
  logic [3:0] mem_rdata = '0;
  logic [3:0] mem_wdata;
  logic       mem_we;
  logic       start_validation;
  logic [3:0] piece_to_move;
  logic [2:0] origin_x, origin_y, destination_x, destination_y;
  logic [3:0] piece_read;
  logic [5:0] address_validator = 6'h15;
  logic       move_valid = 1'b0;
  logic       validate_complete = 1'b0;
  logic       current_player, busy, move_done, move_rejected, game_over, winner;
  logic [3:0] dbg_state;

  logic [3:0]  ram [0:63];
  logic [10:0] exp_q[$];
  logic [10:0] wr_exp;
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          rej_cnt = 0;

  move_controller dut (
    .clk(clk), .reset(reset), .select(select), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .start_validation(start_validation), .piece_to_move(piece_to_move),
    .origin_x(origin_x), .origin_y(origin_y),
    .destination_x(destination_x), .destination_y(destination_y),
    .piece_read(piece_read), .address_validator(address_validator),
    .move_valid(move_valid), .validate_complete(validate_complete),
    .current_player(current_player), .busy(busy), .move_done(move_done),
    .move_rejected(move_rejected), .game_over(game_over), .winner(winner),
    .dbg_state(dbg_state)
  );

  // Clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Board RAM: synchronous read, read-before-write
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] = mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every RAM write must match the head of exp_q
  always @(negedge clk) begin
    #3;
    if (reset && mem_we) begin
      wr_exp = (exp_q.size() > 0) ? exp_q.pop_front() : 11'd0;
      check("ram_write", {1'b1, mem_addr, mem_wdata}, wr_exp);
    end
    if (reset && move_done) done_cnt++;
    if (reset && move_rejected) rej_cnt++;
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic sel(input logic [2:0] x, input logic [2:0] y);
    @(negedge clk); #1;
    select = 1'b1; cursor_x = x; cursor_y = y;
    @(negedge clk); #1;
    select = 1'b0;
  endtask

  task automatic push_move(input logic [2:0] sx, sy, dx, dy, input logic [3:0] pc);
    exp_q.push_back({1'b1, dx, dy, pc});
    exp_q.push_back({1'b1, sx, sy, 4'd0});
  endtask

  task automatic wait_validate(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      tick(1);
      if (start_validation) ok = 1'b1;
    end
    if (!ok) check("validate_entry", start_validation, 1);
  endtask

  // Full move; validator answers in VALIDATE cycle n. lat = select-to-move_done.
  task automatic do_move(input logic [2:0] sx, sy, dx, dy, input int n, input bit valid,
                         output int lat);
    int c0;
    bit ok;
    lat = -1;
    sel(sx, sy);
    tick(2);
    check("src_wait_dst", dbg_state, WAIT_DST);
    sel(dx, dy);
    c0 = cyc;
    wait_validate(ok);
    if (!ok) return;
    for (int k = 1; k <= n; k++) begin
      if (k > 1) tick(1);
      if (k == 2) begin
        check("val_mem_addr", mem_addr, 6'h15);
        check("val_piece_read", piece_read, 4'd9);
        check("val_busy", busy, 1);
      end
      if (k == n) begin
        validate_complete = 1'b1;
        move_valid = valid;
        #1;
      end
    end
    if (!valid) begin
      check("val_reject_pulse", move_rejected, 1);
      tick(1);
      validate_complete = 1'b0;
      check("val_reject_idle", dbg_state, IDLE_SRC);
      return;
    end
    tick(1);
    validate_complete = 1'b0;
    move_valid = 1'b0;
    check("val_drop", start_validation, 0);
    for (int i = 0; i < 8 && lat < 0; i++) begin
      if (move_done) lat = cyc - c0;
      else tick(1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int d0, r0;
    bit ok;
    for (int i = 0; i < 64; i++) ram[i] = 4'd0;
    ram[{3'd4, 3'd1}] = 4'd1;
    ram[{3'd1, 3'd7}] = 4'd8;
    ram[{3'd0, 3'd0}] = 4'd4;
    ram[{3'd1, 3'd0}] = 4'd2;
    ram[{3'd3, 3'd6}] = 4'd7;
    ram[{3'd0, 3'd3}] = 4'd5;
    ram[{3'd0, 3'd7}] = 4'd12;
    ram[6'h15]        = 4'd9;

    // Reset state
    tick(3);
    check("rst_state", dbg_state, IDLE_SRC);
    check("rst_player", current_player, 0);
    check("rst_game_over", {game_over, winner}, 0);
    check("rst_pulses", {move_done, move_rejected, start_validation, mem_we, busy}, 0);
    check("rst_regs", {piece_to_move, origin_x, origin_y, destination_x, destination_y}, 0);
    reset = 1'b1;
    tick(2);

    // White selects a black knight: rejected in CHECK_SRC
    r0 = rej_cnt;
    sel(3'd1, 3'd7);
    tick(1);
    check("enemy_src_pulse", move_rejected, 1);
    tick(1);
    check("enemy_src_idle", dbg_state, IDLE_SRC);
    check("enemy_src_count", rej_cnt - r0, 1);

    // Rook then own knight: reselect, then click knight again to deselect
    sel(3'd0, 3'd0);
    tick(2);
    check("rook_wait", dbg_state, WAIT_DST);
    check("rook_piece", piece_to_move, 4'd4);
    sel(3'd1, 3'd0);
    tick(2);
    check("reselect_state", dbg_state, WAIT_DST);
    check("reselect_origin", {origin_x, origin_y}, {3'd1, 3'd0});
    check("reselect_piece", piece_to_move, 4'd2);
    check("reselect_noval", start_validation, 0);
    r0 = rej_cnt;
    sel(3'd1, 3'd0);
    check("deselect_idle", dbg_state, IDLE_SRC);
    check("deselect_nopulse", rej_cnt - r0, 0);

    // White pawn (4,1)->(4,3), validator completes in cycle 3
    d0 = done_cnt;
    push_move(3'd4, 3'd1, 3'd4, 3'd3, 4'd1);
    do_move(3'd4, 3'd1, 3'd4, 3'd3, 3, 1'b1, lat);
    check("pawn_latency", lat, 7);
    tick(1);
    check("pawn_done_once", done_cnt - d0, 1);
    check("pawn_player", current_player, 1);
    check("pawn_ram_dst", ram[{3'd4, 3'd3}], 4'd1);
    check("pawn_ram_src", ram[{3'd4, 3'd1}], 4'd0);

    // Black pawn move, validator silent: timeout in VALIDATE cycle 255
    r0 = rej_cnt;
    sel(3'd3, 3'd6);
    tick(2);
    sel(3'd3, 3'd4);
    wait_validate(ok);
    validate_complete = 1'b1;
    move_valid = 1'b0;
    tick(1);
    validate_complete = 1'b0;
    check("first_cycle_ignored", dbg_state, VALIDATE);
    tick(252);
    check("tmo_cycle254", {dbg_state, 4'(rej_cnt - r0)}, {VALIDATE, 4'd0});
    tick(1);
    check("tmo_cycle255", move_rejected, 1);
    tick(1);
    check("tmo_idle", dbg_state, IDLE_SRC);
    check("tmo_count", rej_cnt - r0, 1);
    check("tmo_player", current_player, 1);
    check("tmo_board", {ram[{3'd3, 3'd6}], ram[{3'd3, 3'd4}]}, {4'd7, 4'd0});

    // Validator says illegal
    do_move(3'd3, 3'd6, 3'd3, 3'd5, 2, 1'b0, lat);
    check("illegal_player", current_player, 1);

    // Black pawn (3,6)->(3,5), fastest validator: 6-cycle latency
    push_move(3'd3, 3'd6, 3'd3, 3'd5, 4'd7);
    do_move(3'd3, 3'd6, 3'd3, 3'd5, 2, 1'b1, lat);
    check("min_latency", lat, 6);
    tick(1);
    check("black_player", current_player, 0);

    // White queen captures black king
    push_move(3'd0, 3'd3, 3'd0, 3'd7, 4'd5);
    do_move(3'd0, 3'd3, 3'd0, 3'd7, 4, 1'b1, lat);
    check("capture_latency", lat, 8);
    tick(1);
    check("go_state", dbg_state, GAME_OVER);
    check("go_flags", {game_over, winner, busy}, 3'b100);
    d0 = done_cnt;
    r0 = rej_cnt;
    sel(3'd1, 3'd0);
    sel(3'd4, 3'd3);
    tick(4);
    check("go_ignore_state", dbg_state, GAME_OVER);
    check("go_ignore_origin", {origin_x, origin_y}, {3'd0, 3'd3});
    check("go_ignore_pulses", (done_cnt - d0) + (rej_cnt - r0), 0);
    check("go_ram_king", ram[{3'd0, 3'd7}], 4'd5);

    // Reset leaves GAME_OVER
    reset = 1'b0;
    tick(1);
    check("go_reset", {game_over, dbg_state}, {1'b0, IDLE_SRC});
    reset = 1'b1;
    tick(1);

    // White rook move, then reset in the middle of black's validation
    push_move(3'd0, 3'd0, 3'd0, 3'd2, 4'd4);
    do_move(3'd0, 3'd0, 3'd0, 3'd2, 2, 1'b1, lat);
    tick(1);
    check("rook_player", current_player, 1);
    sel(3'd3, 3'd5);
    tick(2);
    sel(3'd3, 3'd4);
    wait_validate(ok);
    tick(1);
    check("pre_reset_val", start_validation, 1);
    reset = 1'b0;
    #1;
    check("async_start_val", start_validation, 0);
    check("async_state", dbg_state, IDLE_SRC);
    check("async_player", current_player, 0);
    check("async_regs", {piece_to_move, origin_x, origin_y, destination_x, destination_y}, 0);
    tick(2);
    reset = 1'b1;
    tick(2);
    check("exp_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/move_controller.md
# move_controller

Turn sequencer for the chess game. It takes square selections from the cursor logic and reads the board memory. It drives the move validator and shares the board memory port with it, commits legal moves by writing the board, and tracks the side to move and the game-over condition. It sits between the cursor/input block, the move validator and the board RAM.

## Interface
- TIMEOUT, 255: maximum cycles spent in VALIDATE before the move is rejected; counter width is 8 bits.
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; low forces the reset state immediately
- select  in  1  one-cycle pulse; cursor square is chosen
- cursor_x, cursor_y  in  3 each  selected square
- mem_addr  out  6  board RAM address, {x[2:0], y[2:0]}
- mem_rdata  in  4  board RAM read data; synchronous, valid 1 cycle after mem_addr
- mem_wdata  out  4  board RAM write data
- mem_we  out  1  board RAM write enable
- start_validation  out  1  held high for the whole of VALIDATE
- piece_to_move  out  4  registered origin piece
- origin_x, origin_y, destination_x, destination_y  out  3 each  registered move squares
- piece_read  out  4  mem_rdata forwarded to the validator
- address_validator  in  6  validator's board address request
- move_valid, validate_complete  in  1 each  validator result
- current_player  out  1  0 = white (pieces 1–6), 1 = black (pieces 7–12)
- busy  out  1  high in any state except IDLE_SRC, WAIT_DST and GAME_OVER
- move_done, move_rejected  out  1 each  one-cycle pulses
- game_over, winner  out  1 each  game_over is sticky; winner is the player who captured the king

## Operation
- Piece codes: 0 empty; 1 pawn, 2 knight, 3 bishop, 4 rook, 5 queen, 6 king (white); 7–12 same order (black).
- Memory arbitration:
  - In VALIDATE, mem_addr = address_validator.
  - Otherwise mem_addr = controller address.
  - mem_we is asserted only in WRITE_DST and WRITE_SRC.
- IDLE_SRC:
  - select → latch cursor as origin → READ_SRC.
- READ_SRC → CHECK_SRC: RAM latency cycle.
- CHECK_SRC:
  - If mem_rdata is owned by current_player → latch piece_to_move → WAIT_DST.
  - Else (empty or enemy) → pulse move_rejected → IDLE_SRC.
- WAIT_DST:
  - select on the origin square → deselect, IDLE_SRC, no pulse.
  - Other select → latch destination → READ_DST → CHECK_DST.
- CHECK_DST:
  - Own piece at destination → reselect: origin ← destination, piece_to_move ← mem_rdata → WAIT_DST.
  - Otherwise latch captured = mem_rdata → VALIDATE.
- VALIDATE:
  - Clear the timeout counter on entry; increment every cycle.
  - validate_complete high on the 2nd or later VALIDATE cycle: move_valid=1 → WRITE_DST; move_valid=0 → pulse move_rejected → IDLE_SRC.
  - Counter reaches TIMEOUT → reject the same way.
- WRITE_DST: mem_we=1, address = destination, data = piece_to_move.
- WRITE_SRC: mem_we=1, address = origin, data = 0.
- DONE:
  - Pulse move_done.
  - If captured ∈ {6, 12}: game_over ← 1, winner ← current_player → GAME_OVER.
  - Else toggle current_player → IDLE_SRC.
- GAME_OVER: all selects are ignored; only reset leaves it.
- select pulses are ignored in every state except IDLE_SRC and WAIT_DST.

## Timing
- Reset values:
  - State IDLE_SRC.
  - All outputs 0, including current_player (white moves first), game_over and winner.
  - Latched squares and pieces 0.
- Source select to WAIT_DST: 2 cycles.
- Destination select to first VALIDATE cycle: 2 cycles.
- Validator complete in cycle N of VALIDATE → move_done asserted at cycle N+3, counting from VALIDATE entry.
- Minimum destination-select-to-move_done time: 6 cycles.
- Reset asserted mid-move (including during WRITE_DST) aborts immediately. The board may be left half-written; a board reload is the owner's responsibility.
- start_validation falls in the cycle after validate_complete is sampled. The validators re-arm from that falling edge.

## Structure
- Shared package chess_pkg holds:
  - piece code constants
  - the owner function (code → player, with an empty flag)
  - the square-to-address packing function
  - the controller state enum
- One sub-module, move_timeout_counter: 8-bit up-counter with clear and enable, plus a terminal flag at TIMEOUT.
- Everything else lives in one FSM plus its registers.

## Test plan
- White pawn at (4,1), select (4,1) then (4,3); validator returns valid after 3 cycles → RAM (4,3)=1, (4,1)=0, move_done once, current_player=1.
- White to move, select a black knight (8) at (1,7) → move_rejected pulse, state IDLE_SRC, no RAM writes.
- Select (0,0) rook, then (1,0) holding a white knight → origin becomes (1,0), piece_to_move=2, no validation started.
- Validator never asserts validate_complete → move_rejected at VALIDATE cycle 255, board unchanged, player unchanged.
- Valid capture of black king (12) by white queen → game_over=1, winner=0; further select pulses produce no activity.
- Assert reset during VALIDATE → all outputs 0 asynchronously, start_validation drops the same cycle, current_player=0.
